modulator_sequencer: RTL and testbench

- Sequences the PWM modulator datapath. It pulls 8-bit samples from an upstream valid/ready stream and presents them to the modulator.
- It issues one new_sample strobe per PWM symbol period and holds the modulator configuration stable for the whole run.
- It handles start/stop and underrun. It sits between the sample FIFO and the modulator.

---
 rtl/modulator_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_modulator_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulator_sequencer.sv
// Feeds one 8-bit sample per PWM symbol period to the modulator, with start/stop and underrun handling.
// Optional MODULATOR_SEQUENCER_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module modulator_sequencer #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [7:0]  IDLE_SAMPLE = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_bits_per_sample,
  input  logic [7:0] cfg_clks_per_pwm_step,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       mod_enable,
  output logic       mod_new_sample,
  output logic [7:0] mod_sample,
  output logic [7:0] mod_bits_per_sample,
  output logic [7:0] mod_clks_per_pwm_step,
  output logic       busy,
  output logic       underrun
`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRIME    = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_STOPPING = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 buf_full_q, buf_full_d;
  logic [7:0]           buf_data_q, buf_data_d;
  logic                 enable_q, enable_d;
  logic                 new_sample_q, new_sample_d;
  logic                 underrun_q, underrun_d;
  logic [7:0]           sample_q, sample_d;
  logic [7:0]           bits_q, bits_d;
  logic [7:0]           clks_q, clks_d;

  logic [15:0] bits_ext, clks_ext, product;
  logic        xfer, boundary, start_accept;

  // Zero configuration values count as one, so the period is never shorter than a clock.
  assign bits_ext = (cfg_bits_per_sample == 8'd0) ? 16'd1 : {8'd0, cfg_bits_per_sample};
  assign clks_ext = (cfg_clks_per_pwm_step == 8'd0) ? 16'd1 : {8'd0, cfg_clks_per_pwm_step};
  assign product  = bits_ext * clks_ext;

  // A stop cycle never accepts data: whatever would arrive is going to be flushed anyway.
  assign s_ready      = !buf_full_q && !stop && (state_q == ST_PRIME || state_q == ST_RUN);
  assign xfer         = s_valid && s_ready;
  assign boundary     = (cnt_q == period_q - CNT_ONE);
  assign start_accept = (state_q == ST_IDLE) && start && !stop;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    buf_full_d   = buf_full_q;
    buf_data_d   = buf_data_q;
    enable_d     = enable_q;
    new_sample_d = 1'b0;
    underrun_d   = 1'b0;
    sample_d     = sample_q;
    bits_d       = bits_q;
    clks_d       = clks_q;

    if (xfer) begin
      buf_full_d = 1'b1;
      buf_data_d = s_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          bits_d   = cfg_bits_per_sample;
          clks_d   = cfg_clks_per_pwm_step;
          period_d = CNT_WIDTH'(product);
          cnt_d    = '0;
          state_d  = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (stop) begin
          buf_full_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (buf_full_q) begin
          sample_d     = buf_data_q;
          new_sample_d = 1'b1;
          enable_d     = 1'b1;
          buf_full_d   = 1'b0;
          cnt_d        = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = boundary ? '0 : cnt_q + CNT_ONE;
        if (boundary && stop) begin
          enable_d   = 1'b0;
          buf_full_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (boundary) begin
          new_sample_d = 1'b1;
          buf_full_d   = 1'b0;
          // A sample arriving in the boundary cycle itself still makes this symbol.
          if (buf_full_q) begin
            sample_d = buf_data_q;
          end else if (xfer) begin
            sample_d = s_data;
          end else begin
            sample_d   = IDLE_SAMPLE;
            underrun_d = 1'b1;
          end
        end else if (stop) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        cnt_d = boundary ? '0 : cnt_q + CNT_ONE;
        if (boundary) begin
          enable_d   = 1'b0;
          buf_full_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      buf_full_q   <= 1'b0;
      buf_data_q   <= 8'd0;
      enable_q     <= 1'b0;
      new_sample_q <= 1'b0;
      underrun_q   <= 1'b0;
      sample_q     <= 8'd0;
      bits_q       <= 8'd0;
      clks_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      buf_full_q   <= buf_full_d;
      buf_data_q   <= buf_data_d;
      enable_q     <= enable_d;
      new_sample_q <= new_sample_d;
      underrun_q   <= underrun_d;
      sample_q     <= sample_d;
      bits_q       <= bits_d;
      clks_q       <= clks_d;
    end
  end

  assign mod_enable            = enable_q;
  assign mod_new_sample        = new_sample_q;
  assign mod_sample            = sample_q;
  assign mod_bits_per_sample   = bits_q;
  assign mod_clks_per_pwm_step = clks_q;
  assign busy                  = (state_q != ST_IDLE);
  assign underrun              = underrun_q;

`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_q;

  // Counts alongside the pulse, so the value already includes the underrun being flagged.
  always_ff @(posedge clk) begin
    if (rst || start_accept) begin
      underrun_count_q <= 16'd0;
    end else if (underrun_d && underrun_count_q != 16'hFFFF) begin
      underrun_count_q <= underrun_count_q + 16'd1;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_modulator_sequencer.sv
// Bench for modulator_sequencer: expected strobe schedule, samples and status derived from the symbol-period arithmetic.
module tb_modulator_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, s_valid;
  logic [7:0] cfg_b, cfg_c, s_data;
  logic       s_ready, mod_enable, mod_new_sample, busy, underrun;
  logic [7:0] mod_sample, mod_bits, mod_clks;
`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] data_arr [8];
  bit         have_arr [8];
  logic [7:0] last_bits, last_clks;

  always #5 clk = ~clk;

  modulator_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .stop                  (stop),
    .cfg_bits_per_sample   (cfg_b),
    .cfg_clks_per_pwm_step (cfg_c),
    .s_data                (s_data),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .mod_enable            (mod_enable),
    .mod_new_sample        (mod_new_sample),
    .mod_sample            (mod_sample),
    .mod_bits_per_sample   (mod_bits),
    .mod_clks_per_pwm_step (mod_clks),
    .busy                  (busy),
    .underrun              (underrun)
`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
    ,
    .underrun_count        (underrun_count)
`endif
  );

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({mod_enable, mod_new_sample, busy, underrun, s_ready} !== 5'b0 ||
        mod_sample !== 8'd0 || mod_bits !== 8'd0 || mod_clks !== 8'd0) begin
      errors++;
      $display("FAIL %s outputs en=%b ns=%b busy=%b und=%b rdy=%b smp=%h bits=%h clks=%h, required all zero",
               name, mod_enable, mod_new_sample, busy, underrun, s_ready, mod_sample, mod_bits, mod_clks);
    end
`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
    checks++;
    if (underrun_count !== 16'd0) begin
      errors++;
      $display("FAIL %s underrun_count got=%0d required=0", name, underrun_count);
    end
`endif
  endtask

  // One complete run: start at t=0, sample 0 offered at t=1, sample k (if present) offered
  // in the cycle of strobe k-1, stop offered j cycles into symbol n.
  task automatic run_case(input int b, input int c, input int n, input int j,
                          input bit chg, input string name);
    int p, t_stop, t_end, k, cum;
    bit st, exp_und;
    logic [7:0] exp_s;
    p      = ((b == 0) ? 1 : b) * ((c == 0) ? 1 : c);
    t_stop = 3 + n * p + j;
    t_end  = 3 + (n + 1) * p;
    cum    = 0;
    have_arr[0] = 1'b1;
    for (int t = 0; t <= t_end + 2; t++) begin
      @(posedge clk); #1;
      start   = (t == 0);
      stop    = (t == t_stop);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      if (t == 0) begin
        cfg_b = 8'(b);
        cfg_c = 8'(c);
      end else begin
        cfg_b = chg ? 8'd9 : 8'($urandom);
        cfg_c = 8'($urandom);
      end
      if (t == 1) begin
        s_valid = 1'b1;
        s_data  = data_arr[0];
      end
      for (int kk = 1; kk <= n; kk++) begin
        if (have_arr[kk] && t == 3 + (kk - 1) * p) begin
          s_valid = 1'b1;
          s_data  = data_arr[kk];
        end
      end
      @(negedge clk);
      k  = (t >= 3) ? (t - 3) / p : 0;
      st = (t >= 3) && ((t - 3) % p == 0) && (k <= n);
      exp_und = st && !have_arr[k];
      if (exp_und) cum++;

      checks++;
      if (mod_new_sample !== st) begin
        errors++;
        $display("FAIL %s strobe t=%0d got=%b required=%b", name, t, mod_new_sample, st);
      end
      checks++;
      if (underrun !== exp_und) begin
        errors++;
        $display("FAIL %s underrun t=%0d got=%b required=%b", name, t, underrun, exp_und);
      end
      if (st) begin
        exp_s = have_arr[k] ? data_arr[k] : 8'h00;
        checks++;
        if (mod_sample !== exp_s) begin
          errors++;
          $display("FAIL %s sample t=%0d symbol=%0d got=%h required=%h", name, t, k, mod_sample, exp_s);
        end
        $display("%s: t=%0d symbol=%0d sample=%h underrun=%b", name, t, k, mod_sample, underrun);
      end
      checks++;
      if (mod_enable !== (t >= 3 && t < t_end)) begin
        errors++;
        $display("FAIL %s enable t=%0d got=%b required=%b", name, t, mod_enable, (t >= 3 && t < t_end));
      end
      checks++;
      if (busy !== (t >= 1 && t < t_end)) begin
        errors++;
        $display("FAIL %s busy t=%0d got=%b required=%b", name, t, busy, (t >= 1 && t < t_end));
      end
      if (t >= 1) begin
        checks++;
        if (mod_bits !== 8'(b) || mod_clks !== 8'(c)) begin
          errors++;
          $display("FAIL %s config t=%0d got=%h/%h required=%h/%h", name, t, mod_bits, mod_clks, 8'(b), 8'(c));
        end
      end
      if (t == 1 || t >= t_stop) begin
        checks++;
        if (s_ready !== (t == 1)) begin
          errors++;
          $display("FAIL %s s_ready t=%0d got=%b required=%b", name, t, s_ready, (t == 1));
        end
      end
`ifdef MODULATOR_SEQUENCER_UNDERRUN_CNT_EN
      if (t >= 1) begin
        checks++;
        if (underrun_count !== 16'(cum)) begin
          errors++;
          $display("FAIL %s underrun_count t=%0d got=%0d required=%0d", name, t, underrun_count, cum);
        end
      end
`endif
    end
    last_bits = 8'(b);
    last_clks = 8'(c);
  endtask

  task automatic fill_random(input int n, input int skip_pct);
    for (int i = 0; i < 8; i++) begin
      data_arr[i] = 8'($urandom);
      have_arr[i] = ($urandom_range(99, 0) >= skip_pct);
    end
    have_arr[0] = 1'b1;
    if (n < 0) have_arr[0] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    s_data = 8'd0; cfg_b = 8'd0; cfg_c = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    last_bits = 8'd0;
    last_clks = 8'd0;
  endtask

  task automatic test_basic();
    data_arr[0] = 8'h10; data_arr[1] = 8'h20; data_arr[2] = 8'h30;
    for (int i = 0; i < 8; i++) have_arr[i] = 1'b1;
    run_case(4, 2, 2, 7, 1'b0, "basic");
  endtask

  task automatic test_underrun();
    data_arr[0] = 8'hA5;
    for (int i = 0; i < 8; i++) have_arr[i] = 1'b0;
    run_case(2, 3, 2, 2, 1'b0, "underrun");
  endtask

  task automatic test_stop();
    fill_random(1, 0);
    run_case(4, 2, 1, 3, 1'b0, "stop");
  endtask

  task automatic test_config_isolation();
    fill_random(2, 0);
    run_case(4, 2, 2, 3, 1'b1, "cfg_iso");
    fill_random(1, 0);
    run_case(9, 1, 1, 0, 1'b0, "cfg_next");
  endtask

  task automatic test_zero_config();
    fill_random(5, 30);
    run_case(0, 0, 5, 0, 1'b0, "zero_cfg");
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1; cfg_b = 8'd7; cfg_c = 8'd7;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (t > 0) begin
        checks++;
        if (busy !== 1'b0 || mod_enable !== 1'b0 || mod_bits !== last_bits || mod_clks !== last_clks) begin
          errors++;
          $display("FAIL start_stop t=%0d busy=%b en=%b bits=%h clks=%h required busy=0 en=0 bits=%h clks=%h",
                   t, busy, mod_enable, mod_bits, mod_clks, last_bits, last_clks);
        end
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    for (int t = 0; t <= 6; t++) begin
      @(posedge clk); #1;
      start   = (t == 0);
      rst     = (t == 5);
      s_valid = (t == 1 || t == 3);
      s_data  = 8'($urandom);
      cfg_b   = 8'd3;
      cfg_c   = 8'd2;
      if (t == 6) begin
        @(negedge clk);
        check_idle_outputs("reset_mid_run");
      end
    end
    last_bits = 8'd0;
    last_clks = 8'd0;
    fill_random(2, 0);
    run_case(3, 2, 2, 1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int b, c, n, p;
    for (int it = 0; it < 15; it++) begin
      b = $urandom_range(5, 0);
      c = $urandom_range(4, 0);
      n = $urandom_range(6, 1);
      p = ((b == 0) ? 1 : b) * ((c == 0) ? 1 : c);
      fill_random(n, 35);
      run_case(b, c, n, $urandom_range(p - 1, 0), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_stop();
    test_config_isolation();
    test_zero_config();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
